// File: rtl/spi_pkg.sv
// Shared SPI receive types and widths used by the slave receiver and its environment.
package spi_pkg;

  localparam int SPI_WORD_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    RECV,
    WAIT_CS
  } spi_rx_state_t;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Serial link plus received-word outputs of the SPI slave receiver.
interface spi_slave_rx_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_WORD_W
);

  logic              sclk;
  logic              cs;
  logic              mosi;
  logic [DATA_W-1:0] dout;
  logic              done;
  logic              busy;
  logic              frame_err;

  modport slave (
    input  sclk, cs, mosi,
    output dout, done, busy, frame_err
  );

  modport master (
    output sclk, cs, mosi,
    input  dout, done, busy, frame_err
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses on the synced level.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   lvl_p1;

  // Synchronizer chain, then one delay flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      lvl_p1  <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d};
      lvl_p1  <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign level = sync_p0[SYNC_STAGES-1];
  assign rise  = level & ~lvl_p1;
  assign fall  = ~level & lvl_p1;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: samples mosi on synced sclk falling edges, emits one word per cs frame.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_WORD_W,
  parameter bit LSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  spi_slave_rx_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic sclk_lvl, sclk_unused_rise, fall_evt;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_unused_rise, mosi_unused_fall;

  spi_rx_state_t     state, state_nxt;
  logic              armed;
  logic [DATA_W-1:0] sr, sr_nxt, dout_r;
  logic [CNT_W-1:0]  cnt;
  logic              last_bit;
  logic              sample_en, cnt_clr, load, done_nxt, err_nxt;
  logic              done_r, err_r;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] s, input logic b);
    if (LSB_FIRST) return {b, s[DATA_W-1:1]};
    else           return {s[DATA_W-2:0], b};
  endfunction

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(bus.sclk),
    .level(sclk_lvl), .rise(sclk_unused_rise), .fall(fall_evt)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .d(bus.cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(bus.mosi),
    .level(mosi_lvl), .rise(mosi_unused_rise), .fall(mosi_unused_fall)
  );

  assign sr_nxt   = shift_in(sr, mosi_lvl);
  assign last_bit = (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // cs_rise has priority over a coincident sclk fall in every busy state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall && armed) state_nxt = LEAD;
      LEAD:    if (cs_rise) state_nxt = IDLE;
               else if (fall_evt) state_nxt = RECV;
      RECV:    if (cs_rise) state_nxt = IDLE;
               else if (fall_evt && last_bit) state_nxt = WAIT_CS;
      WAIT_CS: if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sample_en = 1'b0;
    cnt_clr   = 1'b0;
    load      = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      LEAD: begin
        if (cs_rise)       err_nxt = 1'b1;
        else if (fall_evt) cnt_clr = 1'b1;
      end
      RECV: begin
        if (cs_rise) err_nxt = 1'b1;
        else if (fall_evt) begin
          sample_en = 1'b1;
          if (last_bit) begin
            load     = 1'b1;
            done_nxt = 1'b1;
          end
        end
      end
      WAIT_CS: if (!cs_rise && fall_evt) err_nxt = 1'b1;
      default: ;
    endcase
  end

  // Registered datapath and strobes; armed blocks frames already in flight at reset release
  always_ff @(posedge clk) begin
    if (rst) begin
      armed  <= 1'b0;
      sr     <= '0;
      cnt    <= '0;
      dout_r <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      armed  <= armed | cs_lvl;
      done_r <= done_nxt;
      err_r  <= err_nxt;
      if (cnt_clr)        cnt <= '0;
      else if (sample_en) cnt <= cnt + 1'b1;
      if (sample_en) sr     <= sr_nxt;
      if (load)      dout_r <= sr_nxt;
    end
  end

  assign bus.dout      = dout_r;
  assign bus.done      = done_r;
  assign bus.frame_err = err_r;
  assign bus.busy      = (state != IDLE);

endmodule
